// File: rtl/if_id_skid_stage_pkg.sv
// Shared definitions for the IF/ID skid stage: state encoding, default NOP, perf counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    localparam logic [7:0] DEFAULT_NOP_INSTR = 8'h00;
    localparam int         PERF_CNT_W        = 16;

endpackage

// File: rtl/if_id_skid_stage_if.sv
// One valid/ready channel carrying an instruction/PC pair.
interface if_id_skid_stage_if #(
    parameter int INSTR_W = 8,
    parameter int PC_W    = 8
);
    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;

    modport master (output valid, output instr, output pc, input ready);
    modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/if_id_skid_stage_sat_counter.sv
// Width-parametrised up-counter that sticks at all-ones; cleared only by rst.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with a 2-entry skid buffer and registered up.ready.
// Optional stall/flush counters are built when IF_ID_SKID_PERF_EN is defined.
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 8,
    parameter int                 PC_W      = 8,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    if_id_skid_stage_if.slave  up,
    if_id_skid_stage_if.master dn
`ifdef IF_ID_SKID_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count
`endif
);
    localparam logic [1:0] S_EMPTY = ST_EMPTY;
    localparam logic [1:0] S_BUSY  = ST_BUSY;
    localparam logic [1:0] S_FULL  = ST_FULL;

    logic [1:0]         r_state;
    logic               r_up_ready;
    logic [INSTR_W-1:0] r_main_instr;
    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_pc;

    logic [1:0] w_state_nxt;
    logic       w_up_xfer;
    logic       w_dn_xfer;
    logic       w_main_vld;
    logic       w_ld_main_up;
    logic       w_ld_main_skid;
    logic       w_ld_skid;

    assign w_main_vld = (r_state != S_EMPTY);
    assign w_up_xfer  = up.valid & r_up_ready;
    assign w_dn_xfer  = w_main_vld & dn.ready;

    // Flush overrides every transition, so nothing loads during a flush cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_up   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_up_xfer) begin
                        w_ld_main_up = 1'b1;
                        w_state_nxt  = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_up_xfer && w_dn_xfer) begin
                        w_ld_main_up = 1'b1;
                    end else if (w_up_xfer) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = S_FULL;
                    end else if (w_dn_xfer) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_dn_xfer) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = S_BUSY;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_up_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_up_ready <= (w_state_nxt != S_FULL);
        end
    end

    // Payload registers are load-enabled only; validity lives in r_state.
    always_ff @(posedge clk) begin
        if (w_ld_main_up) begin
            r_main_instr <= up.instr;
            r_main_pc    <= up.pc;
        end else if (w_ld_main_skid) begin
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
        end
        if (w_ld_skid) begin
            r_skid_instr <= up.instr;
            r_skid_pc    <= up.pc;
        end
    end

    assign up.ready = r_up_ready;
    assign dn.valid = w_main_vld;
    assign dn.instr = w_main_vld ? r_main_instr : NOP_INSTR;
    assign dn.pc    = w_main_vld ? r_main_pc    : {PC_W{1'b0}};

`ifdef IF_ID_SKID_PERF_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = w_main_vld & ~dn.ready;
    assign w_flush_inc = flush & w_main_vld;

    pipe_sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stall_inc),
        .o_count (stall_cycles)
    );

    pipe_sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_flush_inc),
        .o_count (flush_count)
    );
`endif
endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: reset, streaming, backpressure, flush, wide instance.
module tb_if_id_skid_stage;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic flush2;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    if_id_skid_stage_if #(.INSTR_W(8),  .PC_W(8))  up_if ();
    if_id_skid_stage_if #(.INSTR_W(8),  .PC_W(8))  dn_if ();
    if_id_skid_stage_if #(.INSTR_W(16), .PC_W(12)) up2_if ();
    if_id_skid_stage_if #(.INSTR_W(16), .PC_W(12)) dn2_if ();

`ifdef IF_ID_SKID_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cycles, flush_count;
    logic [PERF_CNT_W-1:0] stall2, flush2_cnt;
`endif

    if_id_skid_stage #(.INSTR_W(8), .PC_W(8), .NOP_INSTR(8'h00)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .up    (up_if),
        .dn    (dn_if)
`ifdef IF_ID_SKID_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    if_id_skid_stage #(.INSTR_W(16), .PC_W(12), .NOP_INSTR(16'h0013)) dut_wide (
        .clk   (clk),
        .rst   (rst),
        .flush (flush2),
        .up    (up2_if),
        .dn    (dn2_if)
`ifdef IF_ID_SKID_PERF_EN
        ,
        .stall_cycles (stall2),
        .flush_count  (flush2_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] ins, input logic [7:0] pc);
        up_if.valid = v;
        up_if.instr = ins;
        up_if.pc    = pc;
    endtask

    task automatic expect_dn(input string tag, input logic v, input logic [7:0] ins,
                             input logic [7:0] pc, input logic rdy);
        check({tag, ".valid"}, 32'(dn_if.valid), 32'(v));
        check({tag, ".instr"}, 32'(dn_if.instr), 32'(ins));
        check({tag, ".pc"},    32'(dn_if.pc),    32'(pc));
        check({tag, ".up_rdy"}, 32'(up_if.ready), 32'(rdy));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        flush2 = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        dn_if.ready = 1'b0;
        up2_if.valid = 1'b0;
        up2_if.instr = 16'h0000;
        up2_if.pc = 12'h000;
        dn2_if.ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        expect_dn("reset", 1'b0, 8'h00, 8'h00, 1'b1);
        check("wide.idle_nop", 32'(dn2_if.instr), 32'h0013);
        check("wide.idle_valid", 32'(dn2_if.valid), 32'h0);

        // Streaming at full rate
        dn_if.ready = 1'b1;
        drive(1'b1, 8'hA1, 8'h10);
        step(); expect_dn("stream0", 1'b1, 8'hA1, 8'h10, 1'b1);
        drive(1'b1, 8'hB2, 8'h11);
        step(); expect_dn("stream1", 1'b1, 8'hB2, 8'h11, 1'b1);
        drive(1'b1, 8'hC3, 8'h12);
        step(); expect_dn("stream2", 1'b1, 8'hC3, 8'h12, 1'b1);
        drive(1'b0, 8'h00, 8'h00);
        step(); expect_dn("stream_end", 1'b0, 8'h00, 8'h00, 1'b1);

        // Backpressure: three stalled cycles then release
        dn_if.ready = 1'b0;
        drive(1'b1, 8'h01, 8'h20);
        step(); expect_dn("bp0", 1'b1, 8'h01, 8'h20, 1'b1);
        drive(1'b1, 8'h02, 8'h21);
        step(); expect_dn("bp1", 1'b1, 8'h01, 8'h20, 1'b0);
        drive(1'b1, 8'h03, 8'h22);
        step(); expect_dn("bp2", 1'b1, 8'h01, 8'h20, 1'b0);
        dn_if.ready = 1'b1;
        step(); expect_dn("bp_rel0", 1'b1, 8'h02, 8'h21, 1'b1);
        step(); expect_dn("bp_rel1", 1'b1, 8'h03, 8'h22, 1'b1);
        drive(1'b0, 8'h00, 8'h00);
        step(); expect_dn("bp_rel2", 1'b0, 8'h00, 8'h00, 1'b1);

        // Flush while FULL with a competing up transfer
        dn_if.ready = 1'b0;
        drive(1'b1, 8'h11, 8'h30);
        step();
        drive(1'b1, 8'h22, 8'h31);
        step(); expect_dn("fill_full", 1'b1, 8'h11, 8'h30, 1'b0);
        flush = 1'b1;
        drive(1'b1, 8'h55, 8'h32);
        step(); expect_dn("flush_full", 1'b0, 8'h00, 8'h00, 1'b1);
        flush = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        step(); expect_dn("post_flush", 1'b0, 8'h00, 8'h00, 1'b1);
        flush = 1'b1;
        step(); expect_dn("flush_empty", 1'b0, 8'h00, 8'h00, 1'b1);
        flush = 1'b0;

        // Flush coinciding with a down transfer leaves the stage empty
        dn_if.ready = 1'b1;
        drive(1'b1, 8'h66, 8'h40);
        step(); expect_dn("pre_fdn", 1'b1, 8'h66, 8'h40, 1'b1);
        flush = 1'b1;
        drive(1'b1, 8'h67, 8'h41);
        step(); expect_dn("flush_dn", 1'b0, 8'h00, 8'h00, 1'b1);
        flush = 1'b0;
        drive(1'b0, 8'h00, 8'h00);

        // Wide instance passes a full-width payload
        dn2_if.ready = 1'b1;
        up2_if.valid = 1'b1;
        up2_if.instr = 16'hBEEF;
        up2_if.pc = 12'hFFF;
        step();
        check("wide.valid", 32'(dn2_if.valid), 32'h1);
        check("wide.instr", 32'(dn2_if.instr), 32'hBEEF);
        check("wide.pc",    32'(dn2_if.pc),    32'hFFF);
        up2_if.valid = 1'b0;
        step();
        check("wide.back_nop", 32'(dn2_if.instr), 32'h0013);

        // Asynchronous reset mid-cycle with an entry held
        dn_if.ready = 1'b0;
        drive(1'b1, 8'h77, 8'h50);
        step(); expect_dn("pre_rst", 1'b1, 8'h77, 8'h50, 1'b1);
        drive(1'b1, 8'h78, 8'h51);
        step(); expect_dn("pre_rst_full", 1'b1, 8'h77, 8'h50, 1'b0);
        drive(1'b0, 8'h00, 8'h00);
        #3 rst = 1'b1;
        #1 expect_dn("async_rst", 1'b0, 8'h00, 8'h00, 1'b1);
        #1 rst = 1'b0;
        step(); expect_dn("after_rst", 1'b0, 8'h00, 8'h00, 1'b1);

`ifdef IF_ID_SKID_PERF_EN
        check("perf.stall_rst", 32'(stall_cycles), 32'h0);
        check("perf.flush_rst", 32'(flush_count), 32'h0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 8'h90, 8'h60);
            step();
            drive(1'b0, 8'h00, 8'h00);
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("perf.flush_cnt", 32'(flush_count), 32'h2);
        drive(1'b1, 8'h91, 8'h61);
        step();
        drive(1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 70000; k++) step();
        check("perf.stall_sat", 32'(stall_cycles), 32'hFFFF);
        check("perf.flush_hold", 32'(flush_count), 32'h2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised successor to the IF/ID pipeline register.
- Carries an instruction/PC pair between fetch and decode using a valid/ready handshake instead of a bare stall.
- Holds a 2-entry skid buffer, so `up_ready` is a registered signal and full throughput is kept under backpressure.
- Supports synchronous flush (bubble insertion) and a configurable NOP encoding.

Parameters:
- INSTR_W, 8, instruction width in bits.
- PC_W, 8, program-counter width in bits.
- NOP_INSTR, {INSTR_W{1'b0}}, encoding driven on `dn_instr` whenever the stage holds no valid entry.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries.
- up_valid  input  1  fetch side presents an entry.
- up_ready  output  1  stage can accept an entry; registered.
- up_instr  input  INSTR_W  fetched instruction.
- up_pc  input  PC_W  PC of the fetched instruction.
- dn_valid  output  1  decode-side entry valid.
- dn_ready  input  1  decode side accepts; low means stall.
- dn_instr  output  INSTR_W  instruction to decode.
- dn_pc  output  PC_W  PC to decode.

Behaviour:
- Reset (async, active-high):
  - dn_valid=0, dn_instr=NOP_INSTR, dn_pc=0, up_ready=1.
  - Skid entry invalid; state EMPTY.
  - Reset asserted mid-transfer discards everything held.
- Transfers:
  - Up transfer = up_valid & up_ready.
  - Down transfer = dn_valid & dn_ready.
  - Latency 1 cycle (up transfer at edge N appears on dn_* after edge N).
  - Throughput 1 entry/cycle; order strictly preserved.
- States: EMPTY (main invalid), BUSY (main valid, skid empty), FULL (main and skid valid).
  - EMPTY: up transfer -> main<=up, go BUSY; otherwise stay.
  - BUSY, up & down transfer -> main<=up, stay BUSY.
  - BUSY, up only -> skid<=up, go FULL.
  - BUSY, down only -> main invalid, go EMPTY.
  - BUSY, neither -> hold.
  - FULL: up_ready=0, so no up transfer is possible. Down transfer -> main<=skid, skid invalid, go BUSY. Otherwise hold both entries unchanged.
- up_ready is registered: it equals !(next state == FULL), which is 0 only while in FULL.
- dn_* outputs:
  - Driven from the main register only.
  - When dn_valid=0, dn_instr=NOP_INSTR and dn_pc=0; never stale data.
  - Payload must not change while dn_valid=1 and dn_ready=0.
- Flush (synchronous, priority below reset, above all else):
  - Next edge: both entries invalidated, dn_valid=0, dn_instr=NOP_INSTR, dn_pc=0, state EMPTY, up_ready=1.
  - An up transfer in the flush cycle is discarded.
  - Flush while EMPTY is a no-op.
- Simultaneous flush & dn_ready: the down transfer completes (consumer took the entry); nothing else survives.
- up_valid while up_ready=0: ignored, no state change.
- No X propagation: payload registers load only on transfer; the skid payload may hold stale data but is never visible on outputs.

Optional Feature:
- Macro: IF_ID_SKID_PERF_EN.
- When defined, adds two outputs:
  - stall_cycles (16-bit): counts cycles with dn_valid=1 & dn_ready=0.
  - flush_count (16-bit): counts flush assertions that invalidated ≥1 valid entry.
- Both counters saturate at 16'hFFFF, reset to 0 on rst, and are unaffected by flush.
- When not defined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the stage state enum (EMPTY/BUSY/FULL);
  - the default NOP encoding constant;
  - localparam PERF_CNT_W=16.
- One sub-module is natural: pipe_sat_counter (width-parametrised saturating counter with inc/rst), instantiated twice under IF_ID_SKID_PERF_EN.
- The core datapath stays in if_id_skid_stage.

Test Plan:
- Reset with rst pulsed asynchronously mid-cycle -> dn_valid=0, dn_instr=8'h00, dn_pc=8'h00, up_ready=1 immediately, before the next clk edge.
- Streaming, dn_ready=1, up sends (8'hA1,8'h10),(8'hB2,8'h11),(8'hC3,8'h12) on consecutive cycles -> same sequence on dn_* one cycle later, dn_valid continuous, up_ready stays 1.
- Backpressure: dn_ready=0 for 3 cycles while up_valid=1 with 8'h01,8'h02,8'h03 -> main holds 8'h01, skid takes 8'h02, up_ready=0 from the following cycle, 8'h03 held upstream. Release dn_ready -> outputs 8'h01,8'h02,8'h03 in order with no loss or duplication.
- Flush in FULL: flush=1 with up_valid=1, up_instr=8'h55 -> next cycle dn_valid=0, dn_instr=NOP_INSTR, up_ready=1. 8'h55 never appears on dn_instr.
- Parameter sweep: INSTR_W=16, PC_W=12, NOP_INSTR=16'h0013 -> idle dn_instr=16'h0013, transfer 16'hBEEF/12'hFFF passes intact.
- With IF_ID_SKID_PERF_EN: hold dn_ready=0 for 70000 cycles with a valid entry -> stall_cycles saturates at 16'hFFFF. Two effective flushes -> flush_count=2.
